// File: rtl/display_digit_driver.sv
// display_digit_driver: LED clock divider, seg_sel synchronizer, frame-aligned
// double-buffered display word and registered active-low 7-segment decode.
module display_digit_driver #(
   parameter int DIV_HALF = 50000
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic [15:0] disp_data,
   input  logic [3:0]  blank_mask,
   input  logic [3:0]  dp_mask,
   input  logic        lz_en,
   input  logic        load,
   input  logic [1:0]  seg_sel,
   output logic        led_clk,
   output logic [6:0]  cath,
   output logic        dp,
   output logic        pending
);
   localparam logic [6:0] SEG [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };
   logic [19:0] r_cnt;
   logic        r_led_clk;
   logic [1:0]  r_s1;
   logic [1:0]  r_s2;
   logic [15:0] r_p_data;
   logic [3:0]  r_p_blank;
   logic [3:0]  r_p_dp;
   logic        r_p_lz;
   logic        r_pending;
   logic [15:0] r_a_data;
   logic [3:0]  r_a_blank;
   logic [3:0]  r_a_dp;
   logic        r_a_lz;
   logic [6:0]  r_cath;
   logic        r_dp;
   logic        w_wrap;
   logic        w_commit;
   logic [3:0]  w_nib;
   logic        w_hi_zero;
   logic        w_blank;
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_cnt     <= '0;
         r_led_clk <= 1'b0;
      end else begin
         r_cnt     <= w_wrap ? '0 : r_cnt + 20'd1;
         r_led_clk <= w_wrap ? ~r_led_clk : r_led_clk;
      end
   end
   assign w_wrap = (r_cnt == 20'(DIV_HALF - 1));
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= seg_sel;
         r_s2 <= r_s1;
      end
   end
   // Frame wrap is digit 3 -> digit 0 seen on the synchronized index.
   assign w_commit = (r_s1 == 2'd0) && (r_s2 == 2'd3);
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_p_data  <= '0;
         r_p_blank <= '0;
         r_p_dp    <= '0;
         r_p_lz    <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         if (load) begin
            r_p_data  <= disp_data;
            r_p_blank <= blank_mask;
            r_p_dp    <= dp_mask;
            r_p_lz    <= lz_en;
         end
         r_pending <= load ? 1'b1 : (w_commit ? 1'b0 : r_pending);
      end
   end
   // Active takes the pre-load pending contents when load and commit coincide.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_a_data  <= '0;
         r_a_blank <= '0;
         r_a_dp    <= '0;
         r_a_lz    <= 1'b0;
      end else if (w_commit && r_pending) begin
         r_a_data  <= r_p_data;
         r_a_blank <= r_p_blank;
         r_a_dp    <= r_p_dp;
         r_a_lz    <= r_p_lz;
      end
   end
   always_comb begin
      w_nib     = r_a_data[{r_s2, 2'b00} +: 4];
      w_hi_zero = ((r_a_data >> {r_s2, 2'b00}) == 16'h0000);
      w_blank   = r_a_blank[r_s2] || (r_a_lz && (r_s2 != 2'd0) && w_hi_zero);
   end
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_cath <= 7'h7F;
         r_dp   <= 1'b1;
      end else begin
         r_cath <= w_blank ? 7'h7F : SEG[w_nib];
         r_dp   <= ~r_a_dp[r_s2];
      end
   end
   assign led_clk = r_led_clk;
   assign cath    = r_cath;
   assign dp      = r_dp;
   assign pending = r_pending;
endmodule

// File: tb/tb_display_digit_driver.sv
// tb_display_digit_driver: directed checks of divider, reset, frame commit,
// double load, leading-zero suppression, blank/dp and load-on-commit.
module tb_display_digit_driver;
   logic        clk = 1'b0;
   logic        rstb;
   logic [15:0] disp_data;
   logic [3:0]  blank_mask;
   logic [3:0]  dp_mask;
   logic        lz_en;
   logic        load;
   logic [1:0]  seg_sel;
   logic        led_clk;
   logic [6:0]  cath;
   logic        dp;
   logic        pending;
   int          checks = 0;
   int          errors = 0;
   display_digit_driver #(.DIV_HALF(4)) dut (
      .clk(clk), .rstb(rstb), .disp_data(disp_data), .blank_mask(blank_mask),
      .dp_mask(dp_mask), .lz_en(lz_en), .load(load), .seg_sel(seg_sel),
      .led_clk(led_clk), .cath(cath), .dp(dp), .pending(pending)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p, input logic z);
      @(negedge clk);
      disp_data  = d;
      blank_mask = b;
      dp_mask    = p;
      lz_en      = z;
      load       = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask
   task automatic sel(input string tag, input logic [1:0] v, input logic [6:0] ec, input logic ed);
      @(negedge clk);
      seg_sel = v;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_cath"}, 32'(cath), 32'(ec));
      check({tag, "_dp"}, 32'(dp), 32'(ed));
   endtask
   initial begin
      rstb = 1'b0; disp_data = '0; blank_mask = '0; dp_mask = '0;
      lz_en = 1'b0; load = 1'b0; seg_sel = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cath", 32'(cath), 32'h7F);
      check("rst_dp", 32'(dp), 32'd1);
      check("rst_pend", 32'(pending), 32'd0);
      check("rst_led", 32'(led_clk), 32'd0);
      @(negedge clk);
      rstb = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("led_e%0d", k), 32'(led_clk), 32'((k >= 4 && k < 8) ? 1 : 0));
      end
      do_load(16'hBEEF, 4'h0, 4'hF, 1'b0);
      check("pend_set", 32'(pending), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("led_hi", 32'(led_clk), 32'd1);
      check("pre_cath", 32'(cath), 32'h01);
      #2 rstb = 1'b0;
      #1;
      check("mid_led", 32'(led_clk), 32'd0);
      check("mid_cath", 32'(cath), 32'h7F);
      check("mid_dp", 32'(dp), 32'd1);
      check("mid_pend", 32'(pending), 32'd0);
      @(negedge clk);
      rstb = 1'b1;
      // commit at frame wrap
      do_load(16'h1234, 4'h0, 4'b0100, 1'b0);
      check("c_pend1", 32'(pending), 32'd1);
      sel("c_old1", 2'd1, 7'b0000001, 1'b1);
      sel("c_old2", 2'd2, 7'b0000001, 1'b1);
      sel("c_old3", 2'd3, 7'b0000001, 1'b1);
      check("c_pend2", 32'(pending), 32'd1);
      sel("c_d0", 2'd0, 7'b1001100, 1'b1);
      check("c_pend0", 32'(pending), 32'd0);
      @(negedge clk);
      seg_sel = 2'd1;
      repeat (2) @(posedge clk);
      #1;
      check("lat_2", 32'(cath), 32'(7'b1001100));
      @(posedge clk);
      #1;
      check("lat_3", 32'(cath), 32'(7'b0000110));
      check("lat_dp", 32'(dp), 32'd1);
      sel("c_d2", 2'd2, 7'b0010010, 1'b0);
      sel("c_d3", 2'd3, 7'b1001111, 1'b1);
      // double load while pending
      do_load(16'hAAAA, 4'h0, 4'h0, 1'b0);
      do_load(16'h00F0, 4'h0, 4'h0, 1'b0);
      check("dl_pend1", 32'(pending), 32'd1);
      sel("dl_d0", 2'd0, 7'b0000001, 1'b1);
      check("dl_pend0", 32'(pending), 32'd0);
      sel("dl_d1", 2'd1, 7'b0111000, 1'b1);
      sel("dl_d2", 2'd2, 7'b0000001, 1'b1);
      sel("dl_d3", 2'd3, 7'b0000001, 1'b1);
      // leading-zero suppression
      do_load(16'h0000, 4'h0, 4'h0, 1'b1);
      sel("lz0_d0", 2'd0, 7'b0000001, 1'b1);
      sel("lz0_d1", 2'd1, 7'h7F, 1'b1);
      sel("lz0_d2", 2'd2, 7'h7F, 1'b1);
      sel("lz0_d3", 2'd3, 7'h7F, 1'b1);
      do_load(16'h0105, 4'h0, 4'h0, 1'b1);
      sel("lz1_d0", 2'd0, 7'b0100100, 1'b1);
      sel("lz1_d1", 2'd1, 7'b0000001, 1'b1);
      sel("lz1_d2", 2'd2, 7'b1001111, 1'b1);
      sel("lz1_d3", 2'd3, 7'h7F, 1'b1);
      // blank does not affect dp
      do_load(16'h0008, 4'b0001, 4'b0001, 1'b0);
      sel("bd_d0", 2'd0, 7'h7F, 1'b0);
      sel("bd_d1", 2'd1, 7'b0000001, 1'b1);
      // load on the commit cycle
      sel("lc_d3", 2'd3, 7'b0000001, 1'b1);
      do_load(16'h0006, 4'h0, 4'h0, 1'b0);
      @(negedge clk);
      seg_sel = 2'd0;
      @(posedge clk);
      @(negedge clk);
      disp_data = 16'h0007;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("lc_pend", 32'(pending), 32'd1);
      @(posedge clk);
      #1;
      check("lc_d0", 32'(cath), 32'(7'b0100000));
      sel("lc_d1", 2'd1, 7'b0000001, 1'b1);
      sel("lc_j3", 2'd3, 7'b0000001, 1'b1);
      check("lc_pend2", 32'(pending), 32'd1);
      sel("lc_n0", 2'd0, 7'b0001111, 1'b1);
      check("lc_pend0", 32'(pending), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/display_digit_driver.md
# display_digit_driver

Upstream/downstream companion of the 4-digit anode sequencer in the 7-segment display path. It generates the slow LED clock that steps the anode sequencer and consumes the sequencer's 2-bit `seg_sel`. It decodes the selected nibble of a double-buffered 16-bit display word into active-low cathode and decimal-point drive. New display words are committed only at frame boundaries, so a frame never mixes old and new digits.

## Interface
- `DIV_HALF`, default 50000: LED clock half-period in `clk` cycles; legal range 2..2^20-1.
- `clk` in 1: system clock; the only clock used by this block.
- `rstb` in 1: reset, asynchronous, active-low.
- `disp_data` in 16: display word; nibble `[4n+3:4n]` is shown on digit n, digit 3 most significant.
- `blank_mask` in 4: bit n=1 blanks digit n.
- `dp_mask` in 4: bit n=1 lights the decimal point on digit n.
- `lz_en` in 1: leading-zero suppression enable.
- `load` in 1: single-cycle strobe; captures `disp_data`, `blank_mask`, `dp_mask` and `lz_en` into the pending buffer.
- `seg_sel` in 2: digit index from the anode sequencer.
- `led_clk` out 1: registered divided clock; drives the anode sequencer's clock.
- `cath` out 7: `{a,b,c,d,e,f,g}`, active-low.
- `dp` out 1: decimal point, active-low.
- `pending` out 1: a loaded word is waiting for commit.

## Operation
- **Divider**
  - 20-bit counter runs 0..DIV_HALF-1.
  - At DIV_HALF-1 the counter returns to 0 and `led_clk` toggles.
  - Period is 2·DIV_HALF clk cycles, 50% duty.
- **`seg_sel` synchronizer**
  - Two-flop synchronizer: s1 samples `seg_sel`; s2 samples s1.
- **Buffers**
  - The pending and active buffers each hold 16 data + 4 blank + 4 dp + 1 lz bits.
  - `load` writes the pending buffer and sets `pending`. Load while already pending overwrites the buffer; last write wins.
- **Commit (frame wrap)**
  - Commit occurs on the cycle where s1==0 and s2==3.
  - On commit: active ← pending buffer, `pending` cleared.
  - If `pending`=0 at wrap, active is unchanged.
  - `load` on the commit cycle: the old pending contents commit, the new word goes to pending, and `pending` stays 1.
- **Decode** (registered every cycle from s2 and the active buffer)
  - Hex→`cath`:
    - 0→0000001, 1→1001111, 2→0010010, 3→0000110
    - 4→1001100, 5→0100100, 6→0100000, 7→0001111
    - 8→0000000, 9→0000100, A→0001000, b→1100000
    - C→0110001, d→1000010, E→0110000, F→0111000
  - Digit blanked (`cath`=1111111) if `blank_mask[n]`=1.
  - Digit also blanked if `lz_en`=1, n≠0, and nibble n plus every higher nibble are 0. Digit 0 is never suppressed by `lz_en`.
  - `dp` = ~`dp_mask[n]`. `dp` is independent of blanking.

## Timing
- **Reset values**
  - counter 0, `led_clk` 0, s1/s2 0, `pending` 0.
  - Active and pending buffers all 0.
  - `cath`=1111111, `dp`=1.
- **First `led_clk` edge:** first rise at clk edge DIV_HALF after reset release.
- **Latency**
  - `seg_sel` change → `cath`/`dp` update: 3 clk edges (s1, s2, output register).
  - `load` → `pending`=1: 1 edge.
  - Commit → new data on `cath`: 1 edge, and it lands on digit 0 with no glitch cycle.
- **Frame boundary:** new data appears first on digit 0 of the frame following the wrap. Worst-case `load`→display is one full frame plus 3 cycles.
- **Reset mid-operation:** async clear of everything to reset values. A pending word is discarded.
- **`seg_sel` sequences:** any non-wrap jump (e.g. 1→3) is decoded normally and never triggers commit.

## Test plan
- **Reset with DIV_HALF=4:** assert `rstb`=0 mid-count → `led_clk`=0, `cath`=7F, `dp`=1, `pending`=0 immediately. After release, `led_clk` rises at cycle 4 and falls at cycle 8, period 8.
- **Commit at frame wrap:** load 16'h1234, `dp_mask`=4'b0100, step `seg_sel` 0→1→2→3→0→1→2 → commit on wrap. Digits 0..2 then show 4→1001100, 3→0000110, 2→0010010 with `dp`=0 on digit 2 only. Each update lands 3 cycles after its `seg_sel` change.
- **Double load while pending:** load 16'hAAAA, then 16'h00F0 before wrap → `pending` stays 1. After wrap the display shows 00F0 and `pending`=0.
- **Leading-zero suppression:** `lz_en`=1, data 16'h0000 → only digit 0 shows 0000001; digits 1..3 give 1111111. Data 16'h0105 → digit 3 blank, digit 2 shows 1 (1001111), digit 1 shows 0 (0000001).
- **Blank vs dp:** `blank_mask`=4'b0001 with `dp_mask`=4'b0001 → digit 0 `cath`=1111111, `dp`=0.
- **Load on commit cycle:** drive `load` on the s1==0/s2==3 cycle → the previous pending word displays and the new word stays pending (`pending`=1) until the next wrap.
